// File: rtl/tone_generator.sv
// Square-wave tone channel: a 10-bit down-counter stepped by the /16 tick enable
// flips the output each time it expires, giving a half-period of freq ticks.
module tone_generator #(
    parameter int unsigned INITIAL_COUNT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_div16_en,
    input  logic [9:0] freq,
    output logic       audio_out
);

    // Per-instance start offset keeps the three channels out of phase.
    localparam logic [9:0] START_COUNT = 10'(INITIAL_COUNT);

    logic [9:0] count;
    logic       out_level;

    // freq is only looked at on reload, so a new tone value never cuts short
    // the half-period already in progress. freq==0 reloads 1023 (1024 ticks).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= START_COUNT;
            out_level <= 1'b0;
        end else if (clk_div16_en) begin
            if (count == 10'd0) begin
                count     <= freq - 10'd1;
                out_level <= ~out_level;
            end else begin
                count <= count - 10'd1;
            end
        end
    end

    assign audio_out = out_level;

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator: two instances (start offsets 0 and 313) share stimulus;
// a tick-level reference model feeds an expected queue drained by a monitor.
module tb_tone_generator;

    logic       clk;
    logic       reset_n;
    logic       clk_div16_en;
    logic [9:0] freq;
    logic       audio_a;
    logic       audio_b;

    tone_generator #(.INITIAL_COUNT(0)) dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk_div16_en (clk_div16_en),
        .freq         (freq),
        .audio_out    (audio_a)
    );

    tone_generator #(.INITIAL_COUNT(313)) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk_div16_en (clk_div16_en),
        .freq         (freq),
        .audio_out    (audio_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: ticks remaining until the next toggle, per channel
    int   start_offset [2] = '{0, 313};
    int   remaining    [2];
    logic model_level  [2];

    logic [1:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            model_level[i] = 1'b0;
            remaining[i]   = start_offset[i] + 1;
        end
    endfunction

    function automatic void model_edge(input logic rst_low, input logic en, input int f);
        for (int i = 0; i < 2; i++) begin
            if (rst_low) begin
                model_level[i] = 1'b0;
                remaining[i]   = start_offset[i] + 1;
            end else if (en) begin
                remaining[i] = remaining[i] - 1;
                if (remaining[i] == 0) begin
                    model_level[i] = ~model_level[i];
                    remaining[i]   = (f == 0) ? 1024 : f;
                end
            end
        end
    endfunction

    // driver tasks
    task automatic step(input logic en);
        clk_div16_en = en;
        @(posedge clk);
        #1;
        model_edge(!reset_n, en, int'(freq));
        exp_q.push_back({model_level[1], model_level[0]});
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    // Asserts reset between edges, checks the output drops at once, holds, releases.
    task automatic async_reset(input int hold_cycles);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({audio_b, audio_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_out: got %b expected 00 at %0t", {audio_b, audio_a}, $time);
        end
        for (int i = 0; i < hold_cycles; i++) step(1'b1);
        reset_n = 1'b1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [1:0] exp_v;
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({audio_b, audio_a} !== exp_v) begin
                n_fail++;
                $display("FAIL audio_out: got {b,a}=%b expected %b freq=%0d at %0t",
                         {audio_b, audio_a}, exp_v, freq, $time);
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        clk_div16_en = 1'b0;
        freq         = 10'd3;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0);
        reset_n = 1'b1;

        // freq=3 continuous: toggles on ticks 1,4,7,...
        run_ticks(40);

        // freq=0: 1024-tick half-periods once the current one reloads
        freq = 10'd0;
        run_ticks(2100);

        // freq=1 with a 1-in-16 tick pulse
        freq = 10'd1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            for (int j = 0; j < 15; j++) step(1'b0);
        end

        // offset 313 with freq=5: first toggle on tick 314
        freq = 10'd5;
        async_reset(2);
        run_ticks(360);

        // freq change mid-countdown lets the current 10-tick half-period finish
        freq = 10'd10;
        async_reset(1);
        run_ticks(15);
        freq = 10'd2;
        run_ticks(30);

        // reset mid-period, then freq=3 timing repeats
        freq = 10'd3;
        run_ticks(5);
        async_reset(3);
        run_ticks(40);

        // randomized: sparse ticks, occasional tone changes and resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0)
                freq = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 12));
            if ($urandom_range(0, 799) == 0)
                async_reset($urandom_range(1, 3));
            step($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
